mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter that acts as a responder on the processor's single-cycle data bus: 16-bit address, 16-bit write data, write enable, and 16-bit read data. It decodes a three-word window, buffers bytes in a 4-entry FIFO, and serialises them as 8N1 frames on `tx`. The top level instantiates it beside the RAM and muxes `dout` onto the processor's read data when `hit` is high.

## Interface
- `BASE_ADDR`, 16'hFF00: word address of register 0. Window is BASE..BASE+2.
- `DEFAULT_DIV`, 16'd868: reset value of BAUDDIV, in clocks per bit.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `addr` input 16: bus word address from the processor.
- `din` input 16: write data from the processor (processor `dout`).
- `we` input 1: write enable; qualifies `addr`/`din` in the same cycle.
- `dout` output 16: registered read data.
- `hit` output 1: registered; high when `dout` is valid for this block.
- `tx` output 1: serial line; idles high.

## Operation
- Register map, by offset from BASE:
  - +0 TXDATA: a write pushes `din[7:0]`; a read returns 0.
  - +1 STATUS (read):
    - bit0 full.
    - bit1 empty.
    - bit2 busy, meaning FSM not IDLE.
    - bit3 overflow, sticky.
    - bits[6:4] FIFO count, 0..4.
    - all other bits 0.
  - +1 STATUS (write): any write clears overflow.
  - +2 BAUDDIV: read/write, 16 bits. A written value of 0 is stored as 1.
- Writes outside the window are ignored.
- Reads outside the window give `hit`=0 and `dout`=0.
- Push to a full FIFO:
  - the byte is dropped and overflow is set;
  - exception: if a pop occurs on the same edge, the push is accepted and overflow is not set.
- Transmit FSM has four states: IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. The byte is popped into the shift register on that edge.
  - START: `tx`=0 for one bit period, then → DATA with bit index 0.
  - DATA: `tx`=shift[0], LSB first. Shift after each bit period. After bit 7 → STOP.
  - STOP: `tx`=1 for one bit period. At its end:
    - FIFO non-empty → pop and → START (no idle gap);
    - otherwise → IDLE.
- Bit period is BAUDDIV clocks. The bit counter reloads from BAUDDIV at each bit boundary, so a BAUDDIV write mid-frame takes effect at the next bit boundary.

## Timing
- Reset values:
  - `tx`=1, `dout`=0, `hit`=0;
  - FIFO empty, overflow=0, BAUDDIV=DEFAULT_DIV, FSM=IDLE.
- Reset asserted mid-frame:
  - `tx` goes to 1 asynchronously;
  - the frame is abandoned and the FIFO contents are discarded.
- Read latency is 1 cycle: `addr` presented in cycle N gives `dout`/`hit` after edge N, matching the RAM's read timing.
  - A read and write to the same register in the same cycle returns the pre-write value.
- A TXDATA write at edge N into an empty FIFO with the FSM idle:
  - STATUS count=1 is visible to a read issued in cycle N+1;
  - the pop and START happen at edge N+1, and `tx` falls after edge N+1.
- Frame length is exactly 10×BAUDDIV clocks from the `tx` falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the clock immediately after the last stop-bit clock.
- busy=1 from the START entry edge through the final STOP edge.

## Structure
- Package `mmio_pkg` holds:
  - register offsets (OFS_TXDATA=0, OFS_STATUS=1, OFS_BAUD=2);
  - STATUS bit positions;
  - the `tx_state_t` enum (IDLE, START, DATA, STOP).
- Sub-module `byte_fifo`:
  - synchronous, depth 4, width 8;
  - push/pop/full/empty/count ports;
  - simultaneous push and pop when full is legal.
- The top contains the address decode, registers, read-data register, and the FSM with its bit counter and shift register.

## Test plan
- Reset, then read BASE+1 → `hit`=1, `dout`=16'h0002 one cycle later. Read BASE+2 → 16'd868.
- Write BAUDDIV=4, then TXDATA=8'hA5:
  - `tx` low for 4 clocks;
  - then bits 1,0,1,0,0,1,0,1 at 4 clocks each;
  - then high for 4 clocks;
  - 40 clocks total; busy=0 afterwards.
- BAUDDIV=2 with 6 consecutive TXDATA writes (8'h01..8'h06):
  - the first is popped immediately;
  - the next 4 fill the FIFO;
  - the 6th is dropped, so STATUS reads full=1, overflow=1;
  - exactly 5 frames are sent with no idle gaps;
  - a write to STATUS clears overflow.
- Write BAUDDIV=0, then read → 1. Send 8'hFF → frame length 10 clocks.
- Assert `reset` during DATA bit 3 with 2 bytes queued → `tx`=1 immediately, STATUS=16'h0002, no further frames.
- Read address 16'h0010 → `hit`=0, `dout`=0. Write 16'h0010 → no change to any register.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Register offsets, STATUS bit positions and transmit FSM states.
package mmio_pkg;

  localparam logic [1:0] OFS_TXDATA = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_BAUD   = 2'd2;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_BUSY   = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_CNT_LO = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Four-entry byte FIFO feeding the UART shift register.
// A push while full is taken only when a pop shares the edge.
module byte_fifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty,
  output logic [2:0] count
);

  logic [7:0] mem [4];
  logic [1:0] wp;
  logic [1:0] rp;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 3'd4);
  assign empty   = (count == 3'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rp];

  // Pointer and occupancy update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 2'd1;
      if (do_pop)  rp <= rp + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART transmitter responder on the single-cycle data bus.
// Decodes a three-word window and sends 8N1 frames on tx.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  input  logic        we,
  output logic [15:0] dout,
  output logic        hit,
  output logic        tx
);

  logic [15:0] ofs;
  logic        in_win;
  logic        wr_tx;
  logic        wr_stat;
  logic        wr_baud;
  logic [15:0] baud;
  logic        ovf;
  logic [15:0] rdata;
  logic [15:0] status;

  logic [7:0]  f_data;
  logic        f_full;
  logic        f_empty;
  logic [2:0]  f_count;
  logic        pop;

  tx_state_t   state_q;
  tx_state_t   state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [2:0]  idx_q;
  logic [2:0]  idx_d;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic        tick;

  assign ofs     = addr - BASE_ADDR;
  assign in_win  = (ofs < 16'd3);
  assign wr_tx   = we && in_win && (ofs[1:0] == OFS_TXDATA);
  assign wr_stat = we && in_win && (ofs[1:0] == OFS_STATUS);
  assign wr_baud = we && in_win && (ofs[1:0] == OFS_BAUD);
  assign tick    = (cnt_q == 16'd1);

  byte_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_tx),
    .pop   (pop),
    .wdata (din[7:0]),
    .rdata (f_data),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  // STATUS word assembled from live FIFO and FSM state.
  always_comb begin
    status                    = '0;
    status[ST_FULL]           = f_full;
    status[ST_EMPTY]          = f_empty;
    status[ST_BUSY]           = (state_q != IDLE);
    status[ST_OVF]            = ovf;
    status[ST_CNT_LO +: 3]    = f_count;
  end

  // Read mux on pre-write register values.
  always_comb begin
    rdata = '0;
    case (ofs[1:0])
      OFS_STATUS: rdata = status;
      OFS_BAUD:   rdata = baud;
      default:    rdata = '0;
    endcase
  end

  // Divider and sticky overflow registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud <= DEFAULT_DIV;
      ovf  <= 1'b0;
    end else begin
      if (wr_baud) baud <= (din == '0) ? 16'd1 : din;
      if (wr_stat) ovf <= 1'b0;
      else if (wr_tx && f_full && !pop) ovf <= 1'b1;
    end
  end

  // Registered read data, one cycle behind addr like the RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit  <= 1'b0;
      dout <= '0;
    end else begin
      hit  <= in_win;
      dout <= in_win ? rdata : '0;
    end
  end

  // FSM, bit counter and shift register state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'd1;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next state: counter reloads from baud at every bit boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!f_empty) begin
          pop     = 1'b1;
          shift_d = f_data;
          cnt_d   = baud;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          cnt_d   = baud;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d   = baud;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (tick) begin
          if (!f_empty) begin
            pop     = 1'b1;
            shift_d = f_data;
            cnt_d   = baud;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows state, so reset forces idle-high at once.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: read scoreboard plus serial frame monitor.
// Expected bytes are queued on write and checked as frames arrive.
module tb_mmio_uart_tx;

  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] din = '0;
  logic        we = 1'b0;
  logic [15:0] dout;
  logic        hit;
  logic        tx;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .din   (din),
    .we    (we),
    .dout  (dout),
    .hit   (hit),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [16:0] rd_q[$];
  logic [7:0]  tx_q[$];

  int   baud_tb = 868;
  int   frames = 0;
  int   last_end = -1;
  bit   mon_en = 1'b0;
  bit   b2b = 1'b0;

  logic [7:0] m_exp;
  logic [7:0] m_got;
  logic [9:0] m_bits;
  int         m_bad;
  int         m_start;

  // Serial monitor: samples each clock of a frame at the negedge.
  always begin
    @(negedge clk);
    if (mon_en && tx === 1'b0) begin
      m_start = cyc;
      if (b2b && last_end >= 0)
        check("b2b_gap", m_start - last_end, 1);
      check("frame_expected", tx_q.size() > 0, 1);
      if (tx_q.size() > 0) m_exp = tx_q.pop_front();
      else m_exp = 8'h00;
      m_bits = {1'b1, m_exp, 1'b0};
      m_bad = 0;
      m_got = '0;
      for (int k = 0; k < 10; k++) begin
        for (int j = 0; j < baud_tb; j++) begin
          if (k != 0 || j != 0) @(negedge clk);
          if (tx !== m_bits[k]) m_bad++;
          if (j == 0 && k >= 1 && k <= 8) m_got[k-1] = tx;
        end
      end
      check("frame_byte", m_got, m_exp);
      check("frame_shape", m_bad, 0);
      last_end = cyc;
      frames++;
    end
  end

  task automatic rd(input logic [15:0] a, input logic h,
                    input logic [15:0] d, input string tag);
    logic [16:0] e;
    @(negedge clk);
    addr = a;
    we = 1'b0;
    rd_q.push_back({h, d});
    @(posedge clk);
    #1;
    e = rd_q.pop_front();
    check(tag, {15'b0, hit, dout}, {15'b0, e});
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a;
    din = d;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit accept);
    wr(BASE, {8'h00, b});
    if (accept) tx_q.push_back(b);
  endtask

  task automatic wait_frames(input int n, input int limit);
    int k;
    k = 0;
    while (frames < n && k < limit) begin
      @(posedge clk);
      k++;
    end
    check("frame_timeout", frames >= n, 1);
  endtask

  int f0;
  int lows;
  logic [16:0] e;

  initial begin
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_hit", hit, 0);
    check("rst_dout", dout, 0);
    reset = 1'b1;

    rd(BASE + 16'd1, 1'b1, 16'h0002, "rst_status");
    rd(BASE + 16'd2, 1'b1, 16'd868, "rst_baud");
    rd(BASE, 1'b1, 16'h0000, "txdata_read");

    wr(BASE + 16'd2, 16'd4);
    baud_tb = 4;
    rd(BASE + 16'd2, 1'b1, 16'd4, "baud4");
    send(8'hA5, 1'b1);
    rd(BASE + 16'd1, 1'b1, 16'h0010, "count1_next");
    rd(BASE + 16'd1, 1'b1, 16'h0006, "busy_start");
    wait_frames(1, 200);
    rd(BASE + 16'd1, 1'b1, 16'h0002, "idle_after_a5");

    wr(BASE + 16'd2, 16'd2);
    baud_tb = 2;
    last_end = -1;
    b2b = 1'b1;
    f0 = frames;
    for (int i = 1; i <= 6; i++)
      send(8'(i), i <= 5);
    rd(BASE + 16'd1, 1'b1, 16'h004D, "ovf_full");
    wr(BASE + 16'd1, 16'h0000);
    rd(BASE + 16'd1, 1'b1, 16'h0045, "ovf_clear");
    wait_frames(f0 + 5, 400);
    b2b = 1'b0;
    repeat (40) @(negedge clk);
    check("five_frames", frames - f0, 5);
    check("queue_drained", tx_q.size(), 0);
    rd(BASE + 16'd1, 1'b1, 16'h0002, "idle_after_burst");

    wr(BASE + 16'd2, 16'd0);
    rd(BASE + 16'd2, 1'b1, 16'd1, "baud_zero");
    baud_tb = 1;
    f0 = frames;
    send(8'hFF, 1'b1);
    wait_frames(f0 + 1, 100);
    rd(BASE + 16'd1, 1'b1, 16'h0002, "idle_after_ff");

    @(negedge clk);
    addr = BASE + 16'd2;
    din = 16'd9;
    we = 1'b1;
    rd_q.push_back({1'b1, 16'd1});
    @(posedge clk);
    #1;
    we = 1'b0;
    e = rd_q.pop_front();
    check("rw_same_cycle", {15'b0, hit, dout}, {15'b0, e});
    rd(BASE + 16'd2, 1'b1, 16'd9, "baud9");
    wr(BASE + 16'd2, 16'd1);

    f0 = frames;
    rd(16'h0010, 1'b0, 16'h0000, "oow_read");
    rd(BASE + 16'd3, 1'b0, 16'h0000, "oow_above");
    rd(BASE - 16'd1, 1'b0, 16'h0000, "oow_below");
    wr(16'h0010, 16'h0033);
    wr(BASE + 16'd3, 16'h0033);
    rd(BASE + 16'd2, 1'b1, 16'd1, "oow_baud");
    rd(BASE + 16'd1, 1'b1, 16'h0002, "oow_status");
    repeat (30) @(negedge clk);
    check("oow_no_frame", frames - f0, 0);

    mon_en = 1'b0;
    wr(BASE + 16'd2, 16'd4);
    send(8'hA5, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    lows = 0;
    while (tx !== 1'b0 && lows < 100) begin
      @(negedge clk);
      lows++;
    end
    check("rst_test_start", tx, 0);
    repeat (17) @(negedge clk);
    check("bit3_low", tx, 0);
    reset = 1'b0;
    #1;
    check("rst_async_tx", tx, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd(BASE + 16'd1, 1'b1, 16'h0002, "rst_mid_status");
    rd(BASE + 16'd2, 1'b1, 16'd868, "rst_mid_baud");
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("no_tx_after_rst", lows, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
